// File: rtl/kmer_buffer.sv
// kmer_buffer: sliding-window k-mer extractor between the fragment memory
// read stream and the hasher.
//
// Takes one BASE_LEN-bit base per in_valid/in_ready handshake into a
// KMER_LEN-deep shift register. Once the window is full, every accepted base
// produces one packed k-mer (oldest base in the MSBs) on a single registered
// output stage, tagged with the fragment position of its oldest base. The
// window is cleared at each fragment boundary (in_last, or an overrun after
// FRAG_LEN bases).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        base handshake from fragment memory
//   in_base, in_last         base code, final base of fragment
//   out_valid/out_ready      k-mer handshake to hasher
//   out_kmer, out_index      packed k-mer and start index within fragment
//   out_last                 final k-mer of the fragment
//   frag_short               1-cycle pulse: fragment shorter than KMER_LEN
//   frag_err                 1-cycle pulse: FRAG_LEN bases without in_last
module kmer_buffer #(
  parameter int BASE_LEN   = 2,
  parameter int KMER_LEN   = 16,
  parameter int FRAG_LEN   = 256,
  parameter int INDICE_LEN = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BASE_LEN-1:0]          in_base,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [KMER_LEN*BASE_LEN-1:0] out_kmer,
  output logic [INDICE_LEN-1:0]        out_index,
  output logic                         out_last,
  output logic                         frag_short,
  output logic                         frag_err
);
  localparam int W  = KMER_LEN * BASE_LEN;
  localparam int FW = $clog2(KMER_LEN + 1);
  localparam int CW = $clog2(FRAG_LEN + 1);

  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    sr, sr_shift;
  logic [FW-1:0]   fill;
  logic [CW-1:0]   base_cnt;
  logic            accept, take, forced, frag_end, win_full;

  // Single output register: a stalled k-mer blocks input, a taken one frees
  // the slot in the same cycle so a new base can load behind it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign sr_shift = {sr[W-BASE_LEN-1:0], in_base};

  // Base number FRAG_LEN without in_last closes the fragment on its own.
  assign forced   = !in_last && (base_cnt == CW'(FRAG_LEN - 1));
  assign frag_end = in_last || forced;

  // True when the base being accepted completes or advances a full window.
  assign win_full = (state == FULL) || (fill == FW'(KMER_LEN - 1));

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (frag_end)      state_nxt = EMPTY;
      else if (win_full) state_nxt = FULL;
      else               state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      fill       <= '0;
      base_cnt   <= '0;
      out_valid  <= 1'b0;
      out_kmer   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      frag_short <= 1'b0;
      frag_err   <= 1'b0;
    end else begin
      frag_short <= 1'b0;
      frag_err   <= 1'b0;
      if (accept) begin
        if (frag_end) begin
          sr       <= '0;
          fill     <= '0;
          base_cnt <= '0;
        end else begin
          sr       <= sr_shift;
          if (fill != FW'(KMER_LEN)) fill <= fill + 1'b1;
          base_cnt <= base_cnt + 1'b1;
        end
        frag_short <= in_last && !win_full;
        frag_err   <= forced;
      end

      // Load has priority over take so back-to-back k-mers stream at 1/clk.
      if (accept && win_full) begin
        out_valid <= 1'b1;
        out_kmer  <= sr_shift;
        out_index <= INDICE_LEN'(base_cnt) - INDICE_LEN'(KMER_LEN - 1);
        out_last  <= frag_end;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_kmer_buffer.sv
module tb_kmer_buffer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last;
  logic        out_valid, out_ready, out_last, frag_short, frag_err;
  logic [1:0]  in_base;
  logic [31:0] out_kmer;
  logic [14:0] out_index;

  always #5 clk = ~clk;

  kmer_buffer #(.BASE_LEN(2), .KMER_LEN(16), .FRAG_LEN(256), .INDICE_LEN(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kmer(out_kmer),
    .out_index(out_index), .out_last(out_last),
    .frag_short(frag_short), .frag_err(frag_err)
  );

  typedef struct packed {
    logic [31:0] kmer;
    logic [14:0] idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  int          kmer_cnt = 0, short_cnt = 0, err_cnt = 0;
  bit          rand_rdy = 0;
  logic [31:0] m_sr;
  int          m_fill, m_cnt;

  task automatic model_reset();
    m_sr = '0; m_fill = 0; m_cnt = 0;
  endtask

  // Reference window model, updated when a base is seen to be accepted.
  task automatic model_accept(input logic [1:0] b, input logic last);
    logic [31:0] sr_n;
    bit forced;
    sr_n   = {m_sr[29:0], b};
    forced = !last && (m_cnt == 255);
    if (m_fill + 1 >= 16) exp_q.push_back('{sr_n, 15'(m_cnt - 15), last || forced});
    if (last || forced) model_reset();
    else begin
      m_sr   = sr_n;
      m_fill = (m_fill < 16) ? m_fill + 1 : 16;
      m_cnt++;
    end
  endtask

  // Scoreboard: compare every taken k-mer against the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (frag_short) short_cnt++;
      if (frag_err)   err_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL kmer_unexpected got kmer=%h idx=%0d last=%0b", out_kmer, out_index, out_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          kmer_cnt++;
          if ({out_kmer, out_index, out_last} !== {e.kmer, e.idx, e.last}) begin
            errors++;
            $display("FAIL kmer_out got kmer=%h idx=%0d last=%0b want kmer=%h idx=%0d last=%0b",
                     out_kmer, out_index, out_last, e.kmer, e.idx, e.last);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_base(input logic [1:0] b, input logic last);
    bit done;
    done = 0;
    in_valid = 1'b1; in_base = b; in_last = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(b, last);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_base_timeout got in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic send_seq(input logic [1:0] bases[$], input bit last_at_end);
    foreach (bases[i]) send_base(bases[i], last_at_end && (i == bases.size() - 1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      if (exp_q.size() == 0 && !out_valid) ok = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d out_valid=%0b want 0 0", exp_q.size(), out_valid);
    end
  endtask

  function automatic void fill_const(output logic [1:0] q[$], input int n, input logic [1:0] v);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(v);
  endfunction

  function automatic void fill_ramp(output logic [1:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(2'(i));
  endfunction

  function automatic void fill_rand(output logic [1:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(2'($urandom_range(0, 3)));
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_base = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, frag_short, frag_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {out_valid, out_last, frag_short, frag_err});
    end
    checks++;
    if (out_kmer !== 32'h0 || out_index !== 15'h0) begin
      errors++;
      $display("FAIL reset_data got kmer=%h idx=%0d want 0 0", out_kmer, out_index);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_exact();
    logic [1:0] q[$];
    int k0;
    k0 = kmer_cnt;
    fill_const(q, 16, 2'b01);
    send_seq(q, 1);
    checks++;
    if (out_valid !== 1'b1 || out_kmer !== 32'h55555555 || out_index !== 15'd0 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL exact_latency got v=%0b kmer=%h idx=%0d last=%0b want 1 55555555 0 1",
               out_valid, out_kmer, out_index, out_last);
    end
    wait_drain();
    checks++;
    if (kmer_cnt - k0 !== 1) begin
      errors++;
      $display("FAIL exact_count got %0d want 1", kmer_cnt - k0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] q[$];
    fill_ramp(q, 17);
    send_seq(q, 1);
    checks++;
    if (out_valid !== 1'b1 || out_kmer !== 32'h6C6C6C6C || out_index !== 15'd1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got v=%0b kmer=%h idx=%0d last=%0b want 1 6c6c6c6c 1 1",
               out_valid, out_kmer, out_index, out_last);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [1:0] q[$];
    int k0;
    k0 = kmer_cnt;
    out_ready = 1'b0;
    fill_ramp(q, 16);
    send_seq(q, 0);
    in_valid = 1'b1; in_base = 2'd0; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_kmer !== 32'h1B1B1B1B || out_index !== 15'd0) begin
        errors++;
        $display("FAIL stall_hold got rdy=%0b v=%0b kmer=%h idx=%0d want 0 1 1b1b1b1b 0",
                 in_ready, out_valid, out_kmer, out_index);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_base(2'd0, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_drain();
    checks++;
    if (kmer_cnt - k0 !== 2) begin
      errors++;
      $display("FAIL stall_count got %0d want 2", kmer_cnt - k0);
    end
  endtask

  task automatic test_short();
    logic [1:0] q[$];
    int s0;
    s0 = short_cnt;
    fill_rand(q, 10);
    send_seq(q, 1);
    checks++;
    if (frag_short !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse got short=%0b v=%0b want 1 0", frag_short, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (frag_short !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_width got short=%0b v=%0b want 0 0", frag_short, out_valid);
    end
    fill_rand(q, 16);
    send_seq(q, 1);
    wait_drain();
    checks++;
    if (short_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL short_count got %0d want 1", short_cnt - s0);
    end
  endtask

  task automatic test_long_overrun();
    logic [1:0] q[$], q2[$];
    int k0, e0;
    rand_rdy = 1;
    fill_rand(q, 256);
    k0 = kmer_cnt;
    send_seq(q, 1);
    wait_drain();
    checks++;
    if (kmer_cnt - k0 !== 241) begin
      errors++;
      $display("FAIL long_count got %0d want 241", kmer_cnt - k0);
    end
    k0 = kmer_cnt; e0 = err_cnt;
    send_seq(q, 0);
    checks++;
    if (frag_err !== 1'b1 || out_valid !== 1'b1 || out_index !== 15'd240 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL overrun_end got err=%0b v=%0b idx=%0d last=%0b want 1 1 240 1",
               frag_err, out_valid, out_index, out_last);
    end
    @(posedge clk); #1;
    checks++;
    if (frag_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_width got err=%0b want 0", frag_err);
    end
    wait_drain();
    checks++;
    if (kmer_cnt - k0 !== 241 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL overrun_count got kmers=%0d errs=%0d want 241 1", kmer_cnt - k0, err_cnt - e0);
    end
    fill_rand(q2, 16);
    send_seq(q2, 1);
    wait_drain();
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [1:0] q[$];
    out_ready = 1'b0;
    fill_rand(q, 16);
    send_seq(q, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_last, frag_short, frag_err} !== 4'b0 || out_kmer !== 32'h0 || out_index !== 15'h0) begin
      errors++;
      $display("FAIL async_reset got v=%0b kmer=%h idx=%0d want 0 0 0", out_valid, out_kmer, out_index);
    end
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    fill_const(q, 8, 2'b10);
    send_seq(q, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_kmer !== 32'h0 || out_index !== 15'h0) begin
      errors++;
      $display("FAIL fill_reset got v=%0b kmer=%h idx=%0d want 0 0 0", out_valid, out_kmer, out_index);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    fill_const(q, 16, 2'b11);
    send_seq(q, 1);
    checks++;
    if (out_kmer !== 32'hFFFFFFFF || out_index !== 15'd0) begin
      errors++;
      $display("FAIL fresh_window got kmer=%h idx=%0d want ffffffff 0", out_kmer, out_index);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_exact();
    test_back_to_back();
    test_backpressure();
    test_short();
    test_long_overrun();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
